mem_port_arbiter: RTL

Arbiter and sequencer that shares one single-ported unified memory between the pipeline's fetch stage (instruction reads) and memory stage (data loads/stores). It grants one requester at a time, drives the memory request/acknowledge handshake, returns registered read data with a one-cycle ready pulse, and produces per-stage stall signals for the hazard logic. An optional starvation guard bounds how long fetch can be starved by back-to-back data accesses.

---
 rtl/mem_port_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_port_if.sv
// Handshake bundle between the fetch/memory pipeline stages, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the surrounding pipeline plus memory.
interface mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, data first.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after MAX_STARVE back-to-back data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic       clk,
    input  logic       rst,
    mem_port_if.slave  bus,
    output logic       stall_f,
    output logic       stall_m
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic              own;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic              grant_data;

    if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_max_starve
        $error("mem_port_arbiter: MAX_STARVE must be within 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    // Counts data grants that bypassed a waiting fetch; any fetch grant or uncontested data grant clears it.
    assign grant_data = !(bus.if_req && (starve_cnt == 4'(MAX_STARVE)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (bus.dm_req && grant_data) begin
                if (!bus.if_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != 4'(MAX_STARVE)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (bus.if_req) begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign grant_data = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            own         <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dm_req && grant_data) begin
                        own         <= 1'b1;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        state       <= BUSY;
                    end else if (bus.if_req) begin
                        own         <= 1'b0;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        state       <= BUSY;
                    end
                end
                // Request fields stay frozen until the memory acknowledges; stores still capture read data.
                BUSY: begin
                    if (bus.mem_ack) begin
                        mem_valid_q <= 1'b0;
                        if (own) begin
                            dm_rdata_q <= bus.mem_rdata;
                            dm_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ready_q <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if_ready_q <= 1'b0;
                    dm_ready_q <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    if_ready_q  <= 1'b0;
                    dm_ready_q  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ready  = dm_ready_q;

    assign stall_f = bus.if_req & ~if_ready_q;
    assign stall_m = bus.dm_req & ~dm_ready_q;
endmodule
